// File: rtl/hc595_shift_latch_if.sv
// ---------------------------------------------------------------------------
// hc595_shift_latch_if
//
// Pin bundle for the clock-synchronous 74HC595 model. Signal names follow
// the DIP-16 pin numbers so board-level netlists map one-to-one.
//
//   p10  MR    active-low clear of the shift register   (master -> slave)
//   p11  SHCP  shift clock, rising edge shifts            (master -> slave)
//   p12  STCP  storage clock, rising edge latches         (master -> slave)
//   p13  OE    active-low output enable for Q0..Q7        (master -> slave)
//   p14  DS    serial data in                             (master -> slave)
//   p15  Q0, p1..p7 Q1..Q7 latched parallel outputs       (slave -> master)
//   p9   Q7S   serial out, shift register bit 7           (slave -> master)
//
// Handshake: there is no valid/ready pair on this bus. The controller owns
// p10..p14 and changes them at will; the device samples them on the system
// clock and reacts to rising edges of p11/p12. Pin edges must be slower than
// clk/2 so each level is seen for at least one full clk period.
//
// Modports:
//   master : the controller driving the pins (bench or upstream logic)
//   slave  : the hc595_shift_latch device
// ---------------------------------------------------------------------------
interface hc595_shift_latch_if;
    logic p10;
    logic p11;
    logic p12;
    logic p13;
    logic p14;
    logic p15;
    logic p1;
    logic p2;
    logic p3;
    logic p4;
    logic p5;
    logic p6;
    logic p7;
    logic p9;

    modport master (
        output p10, p11, p12, p13, p14,
        input  p15, p1, p2, p3, p4, p5, p6, p7, p9
    );

    modport slave (
        input  p10, p11, p12, p13, p14,
        output p15, p1, p2, p3, p4, p5, p6, p7, p9
    );
endinterface

// File: rtl/hc595_shift_latch.sv
// ---------------------------------------------------------------------------
// hc595_shift_latch
//
// Clock-synchronous model of the 74HC595: 8-bit serial-in shift register
// feeding an 8-bit storage latch, with an asynchronous shift-register clear
// (MR) and an output enable. SHCP/STCP are ordinary inputs sampled on clk;
// their rising edges are found by comparing each sample with the previous
// one, so the whole block lives in the clk domain.
//
// Parameters:
//   SYNC_STAGES  extra synchroniser flops on p11, p12, p14 (0..3). All three
//                pins share the same depth so DS stays aligned with SHCP.
//   OE_FLOAT     value of Q0..Q7 while p13=1: 0 drives 1'b0, 1 drives 1'bz.
//
// Ports:
//   clk   system clock, all sampling on its rising edge
//   rst   asynchronous active-high reset, clears all state
//   bus   hc595_shift_latch_if.slave pin bundle (p10..p15, p1..p7, p9)
// ---------------------------------------------------------------------------
module hc595_shift_latch #(
    parameter int unsigned SYNC_STAGES = 0,
    parameter bit          OE_FLOAT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    hc595_shift_latch_if.slave    bus
);

    // -----------------------------------------------------------------------
    // Pin conditioning. Bundle order: {DS, STCP, SHCP}.
    // -----------------------------------------------------------------------
    logic [2:0] pins_raw;
    logic [2:0] pins_s;
    logic       s11;
    logic       s12;
    logic       s14;
    logic       mr_n;

    assign pins_raw = {bus.p14, bus.p12, bus.p11};
    assign mr_n     = bus.p10;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign pins_s = pins_raw;
    end else begin : g_sync
        logic [2:0] sync_q [SYNC_STAGES];
        logic [2:0] sync_d [SYNC_STAGES];

        always_comb begin
            sync_d[0] = pins_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        // Reset to all-ones so a pin already high at reset release is not
        // mistaken for a fresh rising edge further down the chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= 3'b111;
                end
            end else begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_d[i];
                end
            end
        end

        assign pins_s = sync_q[SYNC_STAGES-1];
    end

    assign s11 = pins_s[0];
    assign s12 = pins_s[1];
    assign s14 = pins_s[2];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0] sh_q;
    logic [7:0] sh_d;
    logic [7:0] st_q;
    logic [7:0] st_d;
    logic       prev11_q;
    logic       prev11_d;
    logic       prev12_q;
    logic       prev12_d;
    logic       shift_edge;
    logic       store_edge;

    always_comb begin
        shift_edge = ~prev11_q & s11;
        store_edge = ~prev12_q & s12;

        // Edge history tracks the pins every cycle, including while MR is
        // low, so releasing MR with SHCP already high gives no phantom shift.
        prev11_d = s11;
        prev12_d = s12;

        sh_d = sh_q;
        if (shift_edge) begin
            sh_d = {sh_q[6:0], s14};
        end

        // The latch always takes the pre-edge shift register, which makes
        // tied SHCP/STCP lag by one stage exactly like the real part.
        st_d = st_q;
        if (store_edge) begin
            st_d = mr_n ? sh_q : 8'h00;
        end
    end

    // Shift register: cleared asynchronously by rst or MR low and held at 0
    // while MR stays low. MR release is effectively synchronous because the
    // register only moves on a detected shift edge.
    always_ff @(posedge clk or posedge rst or negedge mr_n) begin
        if (rst) begin
            sh_q <= 8'h00;
        end else if (!mr_n) begin
            sh_q <= 8'h00;
        end else begin
            sh_q <= sh_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= 8'h00;
            prev11_q <= 1'b1;
            prev12_q <= 1'b1;
        end else begin
            st_q     <= st_d;
            prev11_q <= prev11_d;
            prev12_q <= prev12_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. OE gating is purely combinational; Q7S is never gated.
    // -----------------------------------------------------------------------
    wire [7:0] q_o;

    if (OE_FLOAT) begin : g_oe_float
        assign q_o = bus.p13 ? 8'bzzzz_zzzz : st_q;
    end else begin : g_oe_zero
        assign q_o = bus.p13 ? 8'h00 : st_q;
    end

    assign bus.p15 = q_o[0];
    assign bus.p1  = q_o[1];
    assign bus.p2  = q_o[2];
    assign bus.p3  = q_o[3];
    assign bus.p4  = q_o[4];
    assign bus.p5  = q_o[5];
    assign bus.p6  = q_o[6];
    assign bus.p7  = q_o[7];
    assign bus.p9  = sh_q[7];

endmodule
